udp_depacketizer: RTL and testbench
===================================

# udp_depacketizer

Receive-side counterpart of the IQ streaming transmitter. Accepts bytes from the Ethernet MAC RX interface and filters for IPv4/UDP frames addressed to this node. Checks the 64-bit frame sequence number, reassembles 32-bit IQ samples from the payload and writes them into the sample FIFO that feeds the DAC-side serializer. Sits between the MAC RX FIFO and the TX sample FIFO, in the MAC clock domain.

## Interface

- LOCAL_MAC, 48'h02_12_34_56_78_90, required destination MAC
- LOCAL_IP, {8'd192,8'd168,8'd50,8'd50}, required destination IP
- LOCAL_PORT, 16'd32179, required UDP destination port
- clk  in  1  clock; MAC RX clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte
- rx_dval  in  1  rx_data valid this cycle
- rx_sop  in  1  first byte of frame; qualified by rx_dval
- rx_eop  in  1  last byte of frame; qualified by rx_dval
- rx_err  in  1  MAC error (CRC/length); sampled with rx_eop
- wr_en  out  1  one-cycle write strobe to sample FIFO
- wr_data  out  32  sample {I[15:0], Q[15:0]}
- wr_full  in  1  sample FIFO full
- frame_ok  out  1  pulse: accepted frame completed cleanly
- seq_err  out  1  pulse: sequence number not equal to expected
- ovf  out  1  pulse: sample discarded because wr_full
- ok_count  out  16  accepted frames, wraps
- drop_count  out  16  filtered, truncated, oversize or errored frames, wraps

## Operation

- The block has no backpressure toward the MAC. Every byte with rx_dval=1 is consumed.
- An 11-bit byte index pos is reset to 0 on each rx_sop byte and incremented per valid byte.
- Frame layout, byte index:
  - 0-5: dest MAC
  - 6-11: source MAC (ignored)
  - 12-13: 0x0800
  - 14: 0x45
  - 15-22: ignored
  - 23: 0x11
  - 24-29: ignored
  - 30-33: dest IP
  - 34-35: source port (ignored)
  - 36-37: dest port
  - 38-39: UDP length 0x05C8
  - 40-41: checksum (ignored)
  - 42-49: sequence number, little-endian
  - 50-1513: payload, 366 samples
- States:
  - IDLE: wait for rx_sop.
  - HDR: bytes 0-41, each compared against the table. Any mismatch → DROP.
  - SEQ: bytes 42-49, assembled into rx_seq[63:0].
  - PAY: bytes 50-1513.
  - DROP: discard until rx_eop, then → IDLE.
- Transitions: HDR→SEQ after byte 41. SEQ→PAY after byte 49. PAY→IDLE on rx_eop.
- Sequence check: expected = last accepted rx_seq + 1 (64-bit, wraps).
  - The first accepted frame after reset skips the check.
  - A mismatch pulses seq_err but the frame is still accepted.
  - expected is resynchronised to rx_seq+1 regardless of the check result.
- Sample byte order within each 4-byte group: I[7:0], I[15:8], Q[7:0], Q[15:8]. The group completes on pos ≡ 1 (mod 4).
- On group completion:
  - wr_full=0 → write the sample.
  - wr_full=1 → drop the sample and pulse ovf.
- Frame end in PAY:
  - rx_eop at pos=1513 with rx_err=0 → frame_ok pulse, ok_count+1.
  - Otherwise → drop_count+1. Samples already written are not retracted; a partial trailing sample is discarded.
- Frame end in HDR, SEQ or DROP → drop_count+1, no frame_ok.
- Oversize: a byte at pos>1513 without eop → DROP.
- rx_sop while not IDLE: the current frame is counted as dropped, and the new frame starts at pos=0 in HDR.
- rx_dval=0 cycles are ignored in every state. The block has no timeout.

## Timing

- Reset values: all outputs 0, state IDLE, pos 0, the "first frame" flag set, expected sequence 0.
- rst mid-frame: returns to IDLE on the next edge. Remaining bytes of that frame are ignored until the next rx_sop; they are not counted.
- wr_en/wr_data are registered, asserting in the cycle after the Q[15:8] byte is accepted.
- wr_en is high for exactly one cycle.
- wr_full is sampled in the same cycle as the Q[15:8] byte.
- seq_err is asserted the cycle after byte 49.
- frame_ok is asserted the cycle after the eop byte. Counters update on that same edge.
- Back-to-back frames with zero idle cycles (eop followed immediately by sop) must be handled without a byte lost.
- Maximum sustained rate: one byte per clock.

## Test plan

- Valid frame, seq=0, samples k → {k, ~k} for k=0..365 → 366 wr_en pulses with matching data, frame_ok=1, ok_count=1, seq_err never asserted.
- Three frames with seq 0, 1, 3 → seq_err pulses exactly once, after frame 3 byte 49; ok_count=3.
- Frames with dest port 1234, dest MAC byte 5=0x91, and ethertype 0x86DD → no wr_en, drop_count=3, ok_count=0.
- wr_full held high for sample indices 10-19 of a valid frame → 356 writes, 10 ovf pulses, frame_ok=1.
- Frame truncated with eop at byte 1000, then rx_err=1 at eop of a full frame → drop_count=2, writes stop at sample 237 for the first frame; the partial sample is not written.
- rst for one cycle at byte 600, then a valid frame back-to-back with the previous eop → counters 0 after reset, the new frame gives 366 writes and no seq_err (first-frame rule).

Source files
------------

// File: rtl/udp_depacketizer_if.sv
// udp_depacketizer_if
//   Bundles the MAC RX byte stream, the sample FIFO write port and the
//   status/counter outputs of udp_depacketizer.
//   slave  : depacketizer view (consumes rx_*, wr_full; drives the rest)
//   master : environment view (drives rx_*, wr_full; observes the rest)
//   rx_data/rx_dval/rx_sop/rx_eop/rx_err : MAC RX byte stream
//   wr_en/wr_data/wr_full                 : sample FIFO write port
//   frame_ok/seq_err/ovf                  : single-cycle status pulses
//   ok_count/drop_count                   : wrapping frame counters
interface udp_depacketizer_if;
  logic [7:0]  rx_data;
  logic        rx_dval;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        frame_ok;
  logic        seq_err;
  logic        ovf;
  logic [15:0] ok_count;
  logic [15:0] drop_count;

  modport slave (
    input  rx_data, rx_dval, rx_sop, rx_eop, rx_err, wr_full,
    output wr_en, wr_data, frame_ok, seq_err, ovf, ok_count, drop_count
  );

  modport master (
    output rx_data, rx_dval, rx_sop, rx_eop, rx_err, wr_full,
    input  wr_en, wr_data, frame_ok, seq_err, ovf, ok_count, drop_count
  );
endinterface

// File: rtl/udp_depacketizer.sv
// udp_depacketizer
//   Filters IPv4/UDP frames addressed to this node from the MAC RX byte
//   stream, checks the 64-bit little-endian frame sequence number and
//   reassembles {I,Q} 32-bit samples into the sample FIFO.
//   clk  : MAC RX clock
//   rst  : synchronous, active-high reset
//   bus  : udp_depacketizer_if.slave (RX stream in, FIFO write + status out)
module udp_depacketizer #(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_12_34_56_78_90,
  parameter logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] LOCAL_PORT = 16'd32179
) (
  input  logic                      clk,
  input  logic                      rst,
  udp_depacketizer_if.slave         bus
);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, DROP} state_t;

  localparam logic [10:0] POS_LAST_HDR = 11'd41;
  localparam logic [10:0] POS_LAST_SEQ = 11'd49;
  localparam logic [10:0] POS_LAST_PAY = 11'd1513;

  state_t      state_q, state_d;
  logic [10:0] pos_q, pos_d;
  logic [63:0] seq_q, seq_d;
  logic [63:0] exp_q, exp_d;
  logic        first_q, first_d;
  logic [23:0] smp_q, smp_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        frame_ok_q, frame_ok_d;
  logic        seq_err_q, seq_err_d;
  logic        ovf_q, ovf_d;
  logic [15:0] ok_q, ok_d;
  logic [15:0] drop_q, drop_d;

  // A sop byte is always byte 0 of a header, whatever state we were in.
  state_t      st_eff;
  logic [10:0] pos_eff;
  logic [7:0]  hdr_exp;
  logic        hdr_care;
  logic [2:0]  seq_idx;
  logic [63:0] seq_full;

  always_comb begin
    st_eff  = state_q;
    pos_eff = pos_q;
    if (bus.rx_dval && bus.rx_sop) begin
      st_eff  = HDR;
      pos_eff = '0;
    end
  end

  always_comb begin
    hdr_care = 1'b1;
    hdr_exp  = '0;
    case (pos_eff)
      11'd0:   hdr_exp = LOCAL_MAC[47:40];
      11'd1:   hdr_exp = LOCAL_MAC[39:32];
      11'd2:   hdr_exp = LOCAL_MAC[31:24];
      11'd3:   hdr_exp = LOCAL_MAC[23:16];
      11'd4:   hdr_exp = LOCAL_MAC[15:8];
      11'd5:   hdr_exp = LOCAL_MAC[7:0];
      11'd12:  hdr_exp = 8'h08;
      11'd13:  hdr_exp = 8'h00;
      11'd14:  hdr_exp = 8'h45;
      11'd23:  hdr_exp = 8'h11;
      11'd30:  hdr_exp = LOCAL_IP[31:24];
      11'd31:  hdr_exp = LOCAL_IP[23:16];
      11'd32:  hdr_exp = LOCAL_IP[15:8];
      11'd33:  hdr_exp = LOCAL_IP[7:0];
      11'd36:  hdr_exp = LOCAL_PORT[15:8];
      11'd37:  hdr_exp = LOCAL_PORT[7:0];
      11'd38:  hdr_exp = 8'h05;
      11'd39:  hdr_exp = 8'hC8;
      default: hdr_care = 1'b0;
    endcase
  end

  // Sequence bytes start at 42 (== 2 mod 8), so the byte lane is pos-2.
  assign seq_idx  = pos_eff[2:0] - 3'd2;
  assign seq_full = {bus.rx_data, seq_q[55:0]};

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    seq_d      = seq_q;
    exp_d      = exp_q;
    first_d    = first_q;
    smp_d      = smp_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    frame_ok_d = 1'b0;
    seq_err_d  = 1'b0;
    ovf_d      = 1'b0;
    ok_d       = ok_q;
    drop_d     = drop_q;

    if (bus.rx_dval) begin
      pos_d = pos_eff + 11'd1;
      // Unterminated frame interrupted by a new sop counts as dropped;
      // a sop byte that also ends its own frame can add a second drop.
      if (bus.rx_sop && state_q != IDLE) drop_d = drop_d + 16'd1;

      unique case (st_eff)
        IDLE: begin
          pos_d = pos_q;
        end
        HDR: begin
          if (bus.rx_eop) begin
            drop_d  = drop_d + 16'd1;
            state_d = IDLE;
          end else if (hdr_care && bus.rx_data != hdr_exp) begin
            state_d = DROP;
          end else if (pos_eff == POS_LAST_HDR) begin
            state_d = SEQ;
          end else begin
            state_d = HDR;
          end
        end
        SEQ: begin
          seq_d[{seq_idx, 3'b000} +: 8] = bus.rx_data;
          if (bus.rx_eop) begin
            drop_d  = drop_d + 16'd1;
            state_d = IDLE;
          end else if (pos_eff == POS_LAST_SEQ) begin
            seq_err_d = !first_q && (seq_full != exp_q);
            exp_d     = seq_full + 64'd1;
            first_d   = 1'b0;
            state_d   = PAY;
          end else begin
            state_d = SEQ;
          end
        end
        PAY: begin
          if (pos_eff > POS_LAST_PAY) begin
            if (bus.rx_eop) begin
              drop_d  = drop_d + 16'd1;
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            // Payload starts at 50 (== 2 mod 4): lanes 2,3,0 buffer I lo,
            // I hi, Q lo; lane 1 carries Q hi and completes the sample.
            case (pos_eff[1:0])
              2'd2: smp_d[7:0]   = bus.rx_data;
              2'd3: smp_d[15:8]  = bus.rx_data;
              2'd0: smp_d[23:16] = bus.rx_data;
              default: begin
                if (bus.wr_full) begin
                  ovf_d = 1'b1;
                end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = {smp_q[15:0], bus.rx_data, smp_q[23:16]};
                end
              end
            endcase
            if (bus.rx_eop) begin
              if (pos_eff == POS_LAST_PAY && !bus.rx_err) begin
                frame_ok_d = 1'b1;
                ok_d       = ok_d + 16'd1;
              end else begin
                drop_d = drop_d + 16'd1;
              end
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (bus.rx_eop) begin
            drop_d  = drop_d + 16'd1;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      seq_q      <= '0;
      exp_q      <= '0;
      first_q    <= 1'b1;
      smp_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      frame_ok_q <= 1'b0;
      seq_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      ok_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      seq_q      <= seq_d;
      exp_q      <= exp_d;
      first_q    <= first_d;
      smp_q      <= smp_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      frame_ok_q <= frame_ok_d;
      seq_err_q  <= seq_err_d;
      ovf_q      <= ovf_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.ovf        = ovf_q;
  assign bus.ok_count   = ok_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_udp_depacketizer.sv
// tb_udp_depacketizer
//   Directed bench for udp_depacketizer: builds frames byte by byte,
//   logs FIFO writes and status pulses, and checks counts, data and timing
//   against hand-derived values.
module tb_udp_depacketizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udp_depacketizer_if bus();

  udp_depacketizer #(
    .LOCAL_MAC (48'h02_12_34_56_78_90),
    .LOCAL_IP  ({8'd192, 8'd168, 8'd50, 8'd50}),
    .LOCAL_PORT(16'd32179)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // cyc advances on every posedge; an output caused by a byte driven at
  // cycle c is visible at the negedge of cycle c+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wlog[$];
  int wcyc[$];
  int ovf_n = 0, serr_n = 0, fok_n = 0;
  int serr_cyc = -1, fok_cyc = -1;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wlog.push_back(bus.wr_data);
      wcyc.push_back(cyc);
    end
    if (bus.ovf) ovf_n++;
    if (bus.seq_err) begin serr_n++; serr_cyc = cyc; end
    if (bus.frame_ok) begin fok_n++; fok_cyc = cyc; end
  end

  int c49, c_eop;
  logic [31:0] rst_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] samp(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {kk, ~kk};
  endfunction

  function automatic logic [7:0] fbyte(input int p, input logic [63:0] seq,
                                       input logic [7:0] mac5, input logic [15:0] etype,
                                       input logic [15:0] dport);
    logic [7:0]  b;
    logic [15:0] k;
    logic [63:0] sh;
    b = 8'(p);
    if (p >= 50) begin
      k = 16'((p - 50) / 4);
      case ((p - 50) % 4)
        0: b = k[7:0];
        1: b = k[15:8];
        2: b = ~k[7:0];
        default: b = ~k[15:8];
      endcase
    end else if (p >= 42) begin
      sh = seq >> (8 * (p - 42));
      b  = sh[7:0];
    end else begin
      case (p)
        0: b = 8'h02;  1: b = 8'h12;  2: b = 8'h34;
        3: b = 8'h56;  4: b = 8'h78;  5: b = mac5;
        6, 7, 8, 9, 10, 11: b = 8'hAA;
        12: b = etype[15:8]; 13: b = etype[7:0];
        14: b = 8'h45; 23: b = 8'h11;
        30: b = 8'd192; 31: b = 8'd168; 32: b = 8'd50; 33: b = 8'd50;
        34: b = 8'h12; 35: b = 8'h34;
        36: b = dport[15:8]; 37: b = dport[7:0];
        38: b = 8'h05; 39: b = 8'hC8;
        40, 41: b = 8'hEE;
        default: b = 8'(p);
      endcase
    end
    return b;
  endfunction

  // Sends one frame with no idle cycles around it; full_lo..full_hi are the
  // sample indices during whose Q-high byte wr_full is held.
  task automatic send(input logic [63:0] seq, input logic [7:0] mac5,
                      input logic [15:0] etype, input logic [15:0] dport,
                      input int len, input bit err, input int full_lo,
                      input int full_hi, input int rst_at, input bit no_eop);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      if (p == rst_at + 1) rst_snap = {bus.ok_count, bus.drop_count};
      bus.rx_data = fbyte(p, seq, mac5, etype, dport);
      bus.rx_dval = 1'b1;
      bus.rx_sop  = (p == 0);
      bus.rx_eop  = (p == len - 1) && !no_eop;
      bus.rx_err  = (p == len - 1) && err;
      bus.wr_full = (p >= 50) && ((p - 50) / 4 >= full_lo) && ((p - 50) / 4 <= full_hi);
      rst         = (p == rst_at);
      if (p == 49) c49 = cyc;
      if (bus.rx_eop) c_eop = cyc;
    end
  endtask

  task automatic good(input logic [63:0] seq);
    send(seq, 8'h90, 16'h0800, 16'd32179, 1514, 1'b0, 1000, -1, -1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_dval = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0;
      bus.rx_err = 1'b0; bus.wr_full = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_dval = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0;
    bus.rx_err = 1'b0; bus.wr_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int b, s, f, o, mm, n;

  initial begin
    bus.rx_data = '0; bus.rx_dval = 1'b0; bus.rx_sop = 1'b0;
    bus.rx_eop = 1'b0; bus.rx_err = 1'b0; bus.wr_full = 1'b0;
    rst_snap = '1;
    do_reset();

    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_pulses", {bus.frame_ok, bus.seq_err, bus.ovf}, 0);
    chk("reset_counters", {bus.ok_count, bus.drop_count}, 0);

    // Valid frame seq 0, samples {k,~k}
    b = wlog.size(); s = serr_n; f = fok_n;
    good(64'd0);
    idle(3);
    n = wlog.size() - b;
    chk("t1_writes", n, 366);
    mm = 0;
    for (int i = 0; i < n && i < 366; i++) if (wlog[b + i] !== samp(i)) mm++;
    chk("t1_data_mismatches", mm, 0);
    if (n > 0) chk("t1_first_write_cycle", wcyc[b], c49 + 5);
    chk("t1_frame_ok_pulses", fok_n - f, 1);
    chk("t1_frame_ok_cycle", fok_cyc, c_eop + 1);
    chk("t1_ok_count", bus.ok_count, 1);
    chk("t1_drop_count", bus.drop_count, 0);
    chk("t1_seq_err", serr_n - s, 0);

    // Sequence 1 (in order) then 3 (gap): exactly one seq_err, after byte 49 of seq 3
    good(64'd1);
    idle(2);
    chk("t2_seq1_no_err", serr_n - s, 0);
    good(64'd3);
    idle(3);
    chk("t2_seq_err_pulses", serr_n - s, 1);
    chk("t2_seq_err_cycle", serr_cyc, c49 + 1);
    chk("t2_ok_count", bus.ok_count, 3);

    // Filtered: wrong port, wrong MAC byte 5, IPv6 ethertype
    do_reset();
    b = wlog.size(); f = fok_n;
    send(64'd4, 8'h90, 16'h0800, 16'd1234, 1514, 1'b0, 1000, -1, -1, 1'b0);
    send(64'd4, 8'h91, 16'h0800, 16'd32179, 1514, 1'b0, 1000, -1, -1, 1'b0);
    send(64'd4, 8'h90, 16'h86DD, 16'd32179, 1514, 1'b0, 1000, -1, -1, 1'b0);
    idle(3);
    chk("t3_writes", wlog.size() - b, 0);
    chk("t3_drop_count", bus.drop_count, 3);
    chk("t3_ok_count", bus.ok_count, 0);
    chk("t3_frame_ok", fok_n - f, 0);

    // wr_full during samples 10..19
    b = wlog.size(); o = ovf_n; f = fok_n; s = serr_n;
    send(64'd10, 8'h90, 16'h0800, 16'd32179, 1514, 1'b0, 10, 19, -1, 1'b0);
    idle(3);
    chk("t4_writes", wlog.size() - b, 356);
    chk("t4_ovf_pulses", ovf_n - o, 10);
    chk("t4_frame_ok", fok_n - f, 1);
    if (wlog.size() - b == 356) begin
      chk("t4_data_idx9", wlog[b + 9], samp(9));
      chk("t4_data_after_gap", wlog[b + 10], samp(20));
      chk("t4_data_last", wlog[b + 355], samp(365));
    end

    // Truncated at byte 1000: 237 samples; then full frame with rx_err
    b = wlog.size(); f = fok_n;
    send(64'd11, 8'h90, 16'h0800, 16'd32179, 1001, 1'b0, 1000, -1, -1, 1'b0);
    idle(2);
    chk("t5_trunc_writes", wlog.size() - b, 237);
    if (wlog.size() > b) chk("t5_trunc_last", wlog[wlog.size() - 1], samp(236));
    b = wlog.size();
    send(64'd12, 8'h90, 16'h0800, 16'd32179, 1514, 1'b1, 1000, -1, -1, 1'b0);
    idle(3);
    chk("t5_err_writes", wlog.size() - b, 366);
    chk("t5_frame_ok", fok_n - f, 0);
    chk("t5_drop_count", bus.drop_count, 5);   // 3 filtered + 2 here
    chk("t5_ok_count", bus.ok_count, 1);

    // Oversize: bytes past 1513 without eop
    f = fok_n;
    send(64'd13, 8'h90, 16'h0800, 16'd32179, 1520, 1'b0, 1000, -1, -1, 1'b0);
    idle(3);
    chk("t6_oversize_frame_ok", fok_n - f, 0);
    chk("t6_oversize_drop", bus.drop_count, 6);

    // sop mid-frame, then a valid frame back-to-back
    b = wlog.size(); f = fok_n;
    send(64'd14, 8'h90, 16'h0800, 16'd32179, 100, 1'b0, 1000, -1, -1, 1'b1);
    good(64'd15);
    idle(3);
    chk("t7_writes", wlog.size() - b, 12 + 366);
    chk("t7_drop_count", bus.drop_count, 7);
    chk("t7_ok_count", bus.ok_count, 2);
    chk("t7_seq_err", serr_n - s, 0);

    // rst at byte 600, then valid frame immediately after that frame's eop
    b = wlog.size(); s = serr_n; f = fok_n;
    send(64'd16, 8'h90, 16'h0800, 16'd32179, 1514, 1'b0, 1000, -1, 600, 1'b0);
    good(64'd500);
    idle(3);
    chk("t8_counters_after_rst", rst_snap, 0);
    chk("t8_writes", wlog.size() - b, 137 + 366);
    chk("t8_seq_err", serr_n - s, 0);
    chk("t8_frame_ok", fok_n - f, 1);
    chk("t8_counters", {bus.ok_count, bus.drop_count}, {16'd1, 16'd0});
    if (wlog.size() - b == 503) chk("t8_last_data", wlog[b + 502], samp(365));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
